// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux2 round-robin arbiter.
// Stats width is only used when ARB_STATS_EN is defined.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;
    localparam int   STAT_W = 16;

    // Saturating increment for the activity counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mux_arb_out_stage.sv
// Single-entry output register: holds one word until downstream takes it.
// space is high whenever a new word may be written this cycle.
module mux_arb_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              out_ready,
    output logic              space,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    assign space = !out_valid || out_ready;

    // A push always wins over a pop so back-to-back transfers leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (push) begin
            out_valid <= 1'b1;
            out_data  <= push_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving a shared 2:1 mux with a bounded hold per grant.
// Define ARB_STATS_EN to add grant and sel-toggle activity counters.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              sel,
`ifdef ARB_STATS_EN
    output logic [STAT_W-1:0] gnt_cnt_a,
    output logic [STAT_W-1:0] gnt_cnt_b,
    output logic [STAT_W-1:0] sel_toggles,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [HOLD_W:0] HOLD_MAX = (HOLD_W+1)'(MAX_HOLD);

    arb_state_e        state, state_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic              last, last_d;
    logic              sel_d;
    logic              space;
    logic              a_xfer, b_xfer;
    logic [HOLD_W:0]   hold_inc, hold_sat;

    assign a_ready  = (state == GNT_A) && space;
    assign b_ready  = (state == GNT_B) && space;
    assign a_xfer   = a_valid && a_ready;
    assign b_xfer   = b_valid && b_ready;
    // One extra bit so the increment cannot wrap before saturating.
    assign hold_inc = {1'b0, hold_cnt} + 1'b1;
    assign hold_sat = (hold_inc > HOLD_MAX) ? HOLD_MAX : hold_inc;

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        last_d  = last;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || last == SEL_B)) begin
                    state_d = GNT_A; hold_d = '0; last_d = SEL_A;
                end else if (b_valid) begin
                    state_d = GNT_B; hold_d = '0; last_d = SEL_B;
                end
            end
            GNT_A: begin
                if (!a_valid) begin
                    if (b_valid) begin
                        state_d = GNT_B; hold_d = '0; last_d = SEL_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (a_xfer) begin
                    if (hold_sat == HOLD_MAX && b_valid) begin
                        state_d = GNT_B; hold_d = '0; last_d = SEL_B;
                    end else begin
                        hold_d = hold_sat[HOLD_W-1:0];
                    end
                end
            end
            GNT_B: begin
                if (!b_valid) begin
                    if (a_valid) begin
                        state_d = GNT_A; hold_d = '0; last_d = SEL_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (b_xfer) begin
                    if (hold_sat == HOLD_MAX && a_valid) begin
                        state_d = GNT_A; hold_d = '0; last_d = SEL_A;
                    end else begin
                        hold_d = hold_sat[HOLD_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel follows the grant and keeps its previous value through IDLE.
    assign sel_d = (state_d == GNT_B) ? SEL_B :
                   (state_d == GNT_A) ? SEL_A : sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= SEL_B;
            sel      <= SEL_A;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            last     <= last_d;
            sel      <= sel_d;
        end
    end

    mux_arb_out_stage #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .push      (a_xfer || b_xfer),
        .push_data ((sel == SEL_B) ? b_data : a_data),
        .out_ready (out_ready),
        .space     (space),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_a   <= '0;
            gnt_cnt_b   <= '0;
            sel_toggles <= '0;
        end else begin
            if (a_xfer)        gnt_cnt_a   <= sat_inc(gnt_cnt_a);
            if (b_xfer)        gnt_cnt_b   <= sat_inc(gnt_cnt_b);
            if (sel_d != sel)  sel_toggles <= sat_inc(sel_toggles);
        end
    end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (default build, MAX_HOLD=4).
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, sel, out_valid;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;

    mux2_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; a_valid = 0; b_valid = 0; out_ready = 0;
        a_data = 8'h00; b_data = 8'h00;

        // Reset then idle
        tick(); tick();
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_odata", 32'(out_data), 0);
        chk("rst_ardy", 32'(a_ready), 0);
        chk("rst_brdy", 32'(b_ready), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_sel", 32'(sel), 0);
            chk("idle_ovalid", 32'(out_valid), 0);
            chk("idle_ardy", 32'(a_ready), 0);
            chk("idle_brdy", 32'(b_ready), 0);
        end

        // Single requester A: 11, 22, 33
        a_valid = 1; a_data = 8'h11; out_ready = 1;
        settle();
        chk("single_idle_ardy", 32'(a_ready), 0);
        tick();
        chk("single_gnt_ardy", 32'(a_ready), 1);
        chk("single_gnt_sel", 32'(sel), 0);
        tick();
        chk("single_d11", 32'(out_data), 32'h11);
        chk("single_v11", 32'(out_valid), 1);
        a_data = 8'h22;
        tick();
        chk("single_d22", 32'(out_data), 32'h22);
        a_data = 8'h33;
        tick();
        chk("single_d33", 32'(out_data), 32'h33);
        a_valid = 0;
        tick();
        chk("single_drain_ovalid", 32'(out_valid), 0);
        chk("single_idle_ardy2", 32'(a_ready), 0);

        // Contention: 4 A, 4 B, 4 A with no dead cycle
        rst = 1; tick(); rst = 0;
        a_valid = 1; b_valid = 1;
        tick();
        for (int i = 0; i < 12; i++) begin
            logic exp_a;
            exp_a  = (i < 4) || (i >= 8);
            a_data = 8'hA0 + 8'(i);
            b_data = 8'hB0 + 8'(i);
            settle();
            chk("cont_ardy", 32'(a_ready), 32'(exp_a));
            chk("cont_brdy", 32'(b_ready), 32'(!exp_a));
            chk("cont_sel", 32'(sel), 32'(!exp_a));
            tick();
            chk("cont_data", 32'(out_data), exp_a ? 32'hA0 + i : 32'hB0 + i);
            chk("cont_valid", 32'(out_valid), 1);
        end
        a_valid = 0; b_valid = 0;

        // Backpressure: 5A held for 3 cycles, then 6B,7C,8D, then switch to B
        rst = 1; tick(); rst = 0;
        a_valid = 1; a_data = 8'h5A; out_ready = 1;
        tick();
        out_ready = 0;
        settle();
        chk("bp_first_ardy", 32'(a_ready), 1);
        tick();
        a_data = 8'h6B; b_valid = 1; b_data = 8'hC1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ardy", 32'(a_ready), 0);
            chk("bp_brdy", 32'(b_ready), 0);
            chk("bp_data", 32'(out_data), 32'h5A);
            chk("bp_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1;
        settle();
        chk("bp_rel_ardy", 32'(a_ready), 1);
        tick();
        chk("bp_d6b", 32'(out_data), 32'h6B);
        a_data = 8'h7C;
        settle();
        chk("bp_ardy_7c", 32'(a_ready), 1);
        tick();
        chk("bp_d7c", 32'(out_data), 32'h7C);
        a_data = 8'h8D;
        settle();
        chk("bp_ardy_8d", 32'(a_ready), 1);
        tick();
        chk("bp_d8d", 32'(out_data), 32'h8D);
        chk("bp_sw_brdy", 32'(b_ready), 1);
        chk("bp_sw_ardy", 32'(a_ready), 0);
        chk("bp_sw_sel", 32'(sel), 1);

        // Requester drop: B does 2 transfers, drops with A waiting
        tick();
        chk("drop_dc1", 32'(out_data), 32'hC1);
        b_data = 8'hC2;
        tick();
        chk("drop_dc2", 32'(out_data), 32'hC2);
        b_valid = 0;
        tick();
        chk("drop_to_a_ardy", 32'(a_ready), 1);
        chk("drop_to_a_sel", 32'(sel), 0);
        b_valid = 1; b_data = 8'hE1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'hD0 + 8'(i);
            settle();
            chk("drop_hold_ardy", 32'(a_ready), 1);
            chk("drop_hold_brdy", 32'(b_ready), 0);
            tick();
            chk("drop_hold_data", 32'(out_data), 32'hD0 + i);
        end
        chk("drop_b_brdy", 32'(b_ready), 1);
        chk("drop_b_sel", 32'(sel), 1);
        tick();
        chk("drop_de1", 32'(out_data), 32'hE1);
        b_data = 8'hE2;
        tick();
        chk("drop_de2", 32'(out_data), 32'hE2);
        a_valid = 0; b_valid = 0;
        tick();
        chk("drop_idle_ardy", 32'(a_ready), 0);
        chk("drop_idle_brdy", 32'(b_ready), 0);
        chk("drop_idle_sel", 32'(sel), 1);
        chk("drop_idle_ovalid", 32'(out_valid), 0);

        // Reset mid-burst while out_valid=1 in GNT_A
        a_valid = 1; a_data = 8'h77;
        tick();
        tick();
        chk("mid_pre_valid", 32'(out_valid), 1);
        chk("mid_pre_data", 32'(out_data), 32'h77);
        rst = 1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ardy", 32'(a_ready), 0);
        chk("mid_rst_sel", 32'(sel), 0);
        rst = 0; b_valid = 1;
        settle();
        chk("mid_idle_ardy", 32'(a_ready), 0);
        tick();
        chk("mid_tie_ardy", 32'(a_ready), 1);
        chk("mid_tie_brdy", 32'(b_ready), 0);
        chk("mid_tie_sel", 32'(sel), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 mux datapath between two requesters, A and B.
- Each requester uses a valid/ready handshake.
- The block drives the mux select, registers the selected data into a single output stage and enforces a bounded hold per grant.
- Sits directly in front of the mux2x1 instance in the power-estimation datapath; sel toggling is the activity the VCD flow measures.

Parameters:
DATA_W, 8, width of each requester payload and of out_data
MAX_HOLD, 4, max consecutive transfers granted to one requester while the other is waiting (>=1)
HOLD_W, 3, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
a_valid  input  1  requester A has data
a_data  input  DATA_W  requester A payload
a_ready  output  1  A transfer accepted this cycle when a_valid&&a_ready
b_valid  input  1  requester B has data
b_data  input  DATA_W  requester B payload
b_ready  output  1  B transfer accepted this cycle when b_valid&&b_ready
sel  output  1  mux select: 0=A, 1=B; registered
out_valid  output  1  out_data holds an unconsumed word
out_data  output  DATA_W  registered mux output
out_ready  input  1  downstream accepts out_data when out_valid&&out_ready

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel=0, out_valid=0, out_data=0, a_ready=0, b_ready=0, hold_cnt=0, last=1 (so A wins the first tie).
- FSM states: IDLE, GNT_A, GNT_B. sel is 0 in GNT_A, 1 in GNT_B, and holds its last value in IDLE.
- Output slot free: space = !out_valid || out_ready.
- Ready: a_ready = (state==GNT_A) && space; b_ready = (state==GNT_B) && space. Both are 0 in IDLE. They are never both high.
- Transfer latency: a transfer in cycle N loads out_data with the granted payload and sets out_valid at edge N+1 (1-cycle latency).
- out_valid clears only on out_ready with no new transfer in the same cycle.
- Simultaneous pop and push: out_valid stays 1 and out_data is replaced; zero bubble.
- Backpressure (out_ready=0, out_valid=1): no transfer, grant held, hold_cnt frozen.
- IDLE transitions:
  - only a_valid -> GNT_A
  - only b_valid -> GNT_B
  - both valid -> the requester != last
  - none -> stay IDLE
- Entering a grant: hold_cnt=0 and last=granted side.
- GNT_X, each cycle:
  - Each transfer increments hold_cnt.
  - If the transfer makes hold_cnt==MAX_HOLD and the other side is valid: switch to the other grant next cycle and reset hold_cnt.
  - If X_valid is low: go to the other grant if it is valid, else IDLE.
  - Otherwise stay. If the other side is idle, hold_cnt saturates at MAX_HOLD and X keeps the grant.
- Grant switches take effect only at clock edges. No cycle has both grants, and there is no dead cycle on a direct A<->B switch.
- Reset mid-operation: any pending out_data is discarded, out_valid=0 and the FSM returns to IDLE at that edge. Inputs during the reset cycle are ignored.
- Stability rule for the bench to check: payload must be stable while valid && !ready. The arbiter does not latch unaccepted data.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: adds outputs gnt_cnt_a and gnt_cnt_b (16 bits each) and sel_toggles (16 bits).
  - gnt_cnt_a / gnt_cnt_b: saturating counts of accepted transfers per requester.
  - sel_toggles: saturating count of sel value changes, for switching-activity cross-check against gate-level power.
  - All clear on rst.
- When undefined: these ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package mux_arb_pkg: state enum (IDLE, GNT_A, GNT_B), constants SEL_A=1'b0 and SEL_B=1'b1, stats counter width STAT_W=16.
- One sub-module: mux_arb_out_stage, the single-entry valid/data output register with space generation. FSM and hold counter stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valid low -> sel=0, out_valid=0, a_ready=b_ready=0 for 5 cycles.
- Single requester: a_valid=1 with data 0x11,0x22,0x33 and out_ready=1 -> GNT_A from the next cycle; out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after acceptance.
- Contention with MAX_HOLD=4: a_valid and b_valid held high, out_ready=1 -> after reset the pattern is 4 A transfers, 4 B, 4 A; sel toggles exactly at each switch edge with no idle cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 and data 0x5A -> out_data stays 0x5A, a_ready=0, hold_cnt frozen; on release the transfer resumes with no lost or duplicated word.
- Requester drop: in GNT_B after 2 transfers, b_valid falls while a_valid=1 -> GNT_A next cycle with hold_cnt=0. With a_valid=0 instead -> IDLE.
- Reset mid-burst: rst asserted while out_valid=1 in GNT_A -> next edge out_valid=0 and state IDLE; first grant after release goes to A on a tie.
